// File: rtl/tdp_ram_pkg.sv
// Shared constants and the byte-lane merge helper for the true dual-port RAM.
package tdp_ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_NO_CHANGE   = 2;

    localparam int PRIO_A = 0;
    localparam int PRIO_B = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_W     = 1024;
    localparam int MAX_BYTES = MAX_W / 8;

    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0]     old_w,
        input logic [MAX_W-1:0]     new_w,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_W-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdp_ram_rdpipe.sv
// Per-port read output stage: read-during-write select, out-of-range zeroing
// and an RD_LAT-deep data/valid pipeline.
module tdp_ram_rdpipe
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_WRITE_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic              we,
    input  logic              oor,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] post_word,
    output logic [DATA_W-1:0] q,
    output logic              rvalid
);

    logic              fire;
    logic [DATA_W-1:0] word;

    always_comb begin
        fire = re && !(we && (RDW_MODE == RDW_NO_CHANGE));
        word = old_word;
        if (oor) begin
            word = '0;
        end else if (we && (RDW_MODE == RDW_WRITE_FIRST)) begin
            word = post_word;
        end
    end

    genvar gi;
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
        logic              v_in;
        logic [DATA_W-1:0] d_in;
        logic              valid_d, valid_q;
        logic [DATA_W-1:0] data_d, data_q;

        if (gi == 0) begin : g_head
            assign v_in = fire;
            assign d_in = word;
        end else begin : g_tail
            assign v_in = g_stage[gi-1].valid_q;
            assign d_in = g_stage[gi-1].data_q;
        end

        // Data only advances with a valid beat so q holds between reads.
        always_comb begin
            valid_d = v_in;
            data_d  = v_in ? d_in : data_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end

    assign q      = g_stage[RD_LAT-1].data_q;
    assign rvalid = g_stage[RD_LAT-1].valid_q;

endmodule

// File: rtl/tdp_ram_sync.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write
// behaviour and prioritised same-address write arbitration.
module tdp_ram_sync
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int RD_LAT    = 1,
    parameter int RDW_MODE  = RDW_WRITE_FIRST,
    parameter int COLL_PRIO = PRIO_A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_a,
    input  logic                  re_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     data_a,
    output logic [DATA_W-1:0]     q_a,
    output logic                  rvalid_a,
    input  logic                  we_b,
    input  logic                  re_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     data_b,
    output logic [DATA_W-1:0]     q_b,
    output logic                  rvalid_b,
    output logic                  coll
);

    localparam int              NB        = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W+1)'(DEPTH);

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("tdp_ram_sync: RD_LAT must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W > MAX_W) begin : g_bad_width
        $error("tdp_ram_sync: DATA_W must be a multiple of 8 within the merge helper width");
    end
    if (DEPTH > 2**ADDR_W) begin : g_bad_depth
        $error("tdp_ram_sync: DEPTH exceeds the address space");
    end

    function automatic logic [DATA_W-1:0] merge_w(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        return DATA_W'(be_merge(MAX_W'(old_w), MAX_W'(new_w), MAX_BYTES'(be)));
    endfunction

    logic              in_a, in_b, same_addr;
    logic [NB-1:0]     wbe_a, wbe_b;
    logic [DATA_W-1:0] rd_word_a, rd_word_b, post_a, post_b;
    logic              coll_d, coll_q;

    always_comb begin
        in_a      = {1'b0, addr_a} < DEPTH_CMP;
        in_b      = {1'b0, addr_b} < DEPTH_CMP;
        wbe_a     = (we_a && in_a) ? be_a : '0;
        wbe_b     = (we_b && in_b) ? be_b : '0;
        same_addr = (addr_a == addr_b);
        post_a    = merge_w(rd_word_a, data_a, wbe_a);
        post_b    = merge_w(rd_word_b, data_b, wbe_b);
        // A shared address ends up with both writes applied, winner last.
        if (same_addr) begin
            if (COLL_PRIO == PRIO_A) begin
                post_a = merge_w(merge_w(rd_word_a, data_b, wbe_b), data_a, wbe_a);
            end else begin
                post_a = merge_w(merge_w(rd_word_a, data_a, wbe_a), data_b, wbe_b);
            end
            post_b = post_a;
        end
        coll_d = same_addr && (|(wbe_a & wbe_b));
    end

    genvar gi;
    for (gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem [0:DEPTH-1];

        // The later non-blocking write wins, so the priority port goes second.
        always_ff @(posedge clk) begin
            if (COLL_PRIO == PRIO_A) begin
                if (wbe_b[gi]) mem[addr_b] <= data_b[8*gi +: 8];
                if (wbe_a[gi]) mem[addr_a] <= data_a[8*gi +: 8];
            end else begin
                if (wbe_a[gi]) mem[addr_a] <= data_a[8*gi +: 8];
                if (wbe_b[gi]) mem[addr_b] <= data_b[8*gi +: 8];
            end
        end

        assign rd_word_a[8*gi +: 8] = mem[addr_a];
        assign rd_word_b[8*gi +: 8] = mem[addr_b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign coll = coll_q;

    tdp_ram_rdpipe #(
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .RDW_MODE (RDW_MODE)
    ) u_rdpipe_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .re        (re_a),
        .we        (we_a),
        .oor       (!in_a),
        .old_word  (rd_word_a),
        .post_word (post_a),
        .q         (q_a),
        .rvalid    (rvalid_a)
    );

    tdp_ram_rdpipe #(
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .RDW_MODE (RDW_MODE)
    ) u_rdpipe_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .re        (re_b),
        .we        (we_b),
        .oor       (!in_b),
        .old_word  (rd_word_b),
        .post_word (post_b),
        .q         (q_b),
        .rvalid    (rvalid_b)
    );

endmodule

// File: tb/tb_tdp_ram_sync.sv
// Scoreboard bench driving three differently configured RAM instances
// (latency, read-during-write mode, collision priority) with shared stimulus.
module tb_tdp_ram_sync;
    import tdp_ram_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 6;
    localparam int DEP = 48;
    localparam int NI  = 3;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction
    function automatic int mode_of(input int i);
        return (i == 0) ? RDW_WRITE_FIRST : ((i == 1) ? RDW_READ_FIRST : RDW_NO_CHANGE);
    endfunction
    function automatic int prio_of(input int i);
        return (i == 1) ? PRIO_B : PRIO_A;
    endfunction

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we_a, re_a, we_b, re_b;
    logic [1:0]    be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;
    logic [DW-1:0] q_a [NI];
    logic [DW-1:0] q_b [NI];
    logic          rvalid_a [NI];
    logic          rvalid_b [NI];
    logic          coll [NI];

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : g_dut
        tdp_ram_sync #(
            .DATA_W    (DW),
            .ADDR_W    (AW),
            .DEPTH     (DEP),
            .RD_LAT    (lat_of(gi)),
            .RDW_MODE  (mode_of(gi)),
            .COLL_PRIO (prio_of(gi))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_a     (we_a),
            .re_a     (re_a),
            .be_a     (be_a),
            .addr_a   (addr_a),
            .data_a   (data_a),
            .q_a      (q_a[gi]),
            .rvalid_a (rvalid_a[gi]),
            .we_b     (we_b),
            .re_b     (re_b),
            .be_b     (be_b),
            .addr_b   (addr_b),
            .data_b   (data_b),
            .q_b      (q_b[gi]),
            .rvalid_b (rvalid_b[gi]),
            .coll     (coll[gi])
        );
    end

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          sb [NI*2][$];
    logic [DW-1:0] last_q [NI*2];
    logic [DW-1:0] mdl [NI][64];
    logic          coll_exp;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_txn = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    function automatic logic [DW-1:0] lanes(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [1:0] be);
        logic [DW-1:0] r;
        r = o;
        if (be[0]) r[7:0]  = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                int            k;
                logic          v;
                logic [DW-1:0] q;
                exp_t          e;
                k = i*2 + p;
                v = (p == 0) ? rvalid_a[i] : rvalid_b[i];
                q = (p == 0) ? q_a[i] : q_b[i];
                if (sb[k].size() > 0 && sb[k][0].due == edge_cnt) begin
                    e = sb[k].pop_front();
                    check_val($sformatf("rvalid u%0d.%s", i, p ? "b" : "a"), 32'(v), 32'd1);
                    check_val($sformatf("q u%0d.%s", i, p ? "b" : "a"), 32'(q), 32'(e.val));
                    last_q[k] = e.val;
                end else begin
                    check_val($sformatf("rvalid_idle u%0d.%s", i, p ? "b" : "a"), 32'(v), 32'd0);
                    check_val($sformatf("q_hold u%0d.%s", i, p ? "b" : "a"), 32'(q), 32'(last_q[k]));
                end
            end
            check_val($sformatf("coll u%0d", i), 32'(coll[i]), 32'(coll_exp));
        end
    endtask

    task automatic set_idle();
        we_a = 1'b0; re_a = 1'b0; be_a = '0; addr_a = '0; data_a = '0;
        we_b = 1'b0; re_b = 1'b0; be_b = '0; addr_b = '0; data_b = '0;
    endtask

    task automatic step(input logic wa, input logic ra, input logic [1:0] ba,
                        input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic wb, input logic rb, input logic [1:0] bb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db);
        logic          ina, inb;
        logic [1:0]    ea, eb;
        logic [DW-1:0] old_a, old_b, va, vb;
        exp_t          e;
        @(negedge clk);
        check_outputs();
        we_a = wa; re_a = ra; be_a = ba; addr_a = aa; data_a = da;
        we_b = wb; re_b = rb; be_b = bb; addr_b = ab; data_b = db;
        ina = (int'(aa) < DEP);
        inb = (int'(ab) < DEP);
        ea  = (wa && ina) ? ba : 2'b00;
        eb  = (wb && inb) ? bb : 2'b00;
        coll_exp = wa && wb && ina && inb && (aa == ab) && (|(ba & bb));
        for (int i = 0; i < NI; i++) begin
            old_a = mdl[i][aa];
            old_b = mdl[i][ab];
            if (prio_of(i) == PRIO_A) begin
                mdl[i][ab] = lanes(mdl[i][ab], db, eb);
                mdl[i][aa] = lanes(mdl[i][aa], da, ea);
            end else begin
                mdl[i][aa] = lanes(mdl[i][aa], da, ea);
                mdl[i][ab] = lanes(mdl[i][ab], db, eb);
            end
            va = !ina ? '0 : ((wa && mode_of(i) == RDW_WRITE_FIRST) ? mdl[i][aa] : old_a);
            vb = !inb ? '0 : ((wb && mode_of(i) == RDW_WRITE_FIRST) ? mdl[i][ab] : old_b);
            if (ra && !(wa && mode_of(i) == RDW_NO_CHANGE)) begin
                e.due = edge_cnt + lat_of(i);
                e.val = va;
                sb[i*2].push_back(e);
            end
            if (rb && !(wb && mode_of(i) == RDW_NO_CHANGE)) begin
                e.due = edge_cnt + lat_of(i);
                e.val = vb;
                sb[i*2+1].push_back(e);
            end
        end
        n_txn++;
        $display("txn %0d: A we=%0b re=%0b be=%b addr=%0d d=%h | B we=%0b re=%0b be=%b addr=%0d d=%h",
                 n_txn, wa, ra, ba, aa, da, wb, rb, bb, ab, db);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic flush_model();
        for (int k = 0; k < NI*2; k++) begin
            sb[k].delete();
            last_q[k] = '0;
        end
        coll_exp = 1'b0;
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b0;
        set_idle();
        flush_model();
        repeat (n) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;
    endtask

    task automatic rand_step();
        logic [AW-1:0] aa, ab;
        aa = AW'($urandom_range(0, 55));
        ab = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, 55));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             aa, 16'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ab, 16'($urandom));
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        flush_model();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        rst_n = 1'b1;

        // Give every in-range word a known value.
        for (int k = 0; k < 24; k++) begin
            step(1'b1, 1'b0, 2'b11, AW'(k), 16'h0100 + 16'(k * 37),
                 1'b1, 1'b0, 2'b11, AW'(k + 24), 16'h8000 + 16'(k * 91));
        end

        // Basic write on A, read on B
        step(1'b1, 1'b0, 2'b11, 6'd3, 16'h00A5, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0,    1'b0, 1'b1, 2'b00, 6'd3, 16'h0);
        idle_step();

        // Same-port read during write
        step(1'b1, 1'b0, 2'b11, 6'd5, 16'h0011, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        step(1'b1, 1'b1, 2'b11, 6'd5, 16'h0022, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0,    1'b0, 1'b1, 2'b00, 6'd5, 16'h0);

        // Byte lanes
        step(1'b1, 1'b0, 2'b11, 6'd7, 16'hBEEF, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        step(1'b1, 1'b1, 2'b01, 6'd7, 16'h1234, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        step(1'b0, 1'b1, 2'b00, 6'd7, 16'h0,    1'b0, 1'b0, 2'b00, 6'd0, 16'h0);

        // Full collision with reads on both ports, then readback
        step(1'b1, 1'b1, 2'b11, 6'd9, 16'h00AA, 1'b1, 1'b1, 2'b11, 6'd9, 16'h0055);
        step(1'b0, 1'b1, 2'b00, 6'd9, 16'h0,    1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        idle_step();
        // Partial overlap and disjoint lanes at a shared address
        step(1'b1, 1'b0, 2'b01, 6'd10, 16'h1111, 1'b1, 1'b1, 2'b11, 6'd10, 16'h2222);
        step(1'b1, 1'b0, 2'b01, 6'd11, 16'h00AB, 1'b1, 1'b0, 2'b10, 6'd11, 16'hCD00);
        step(1'b0, 1'b1, 2'b00, 6'd10, 16'h0,    1'b0, 1'b1, 2'b00, 6'd11, 16'h0);

        // Cross-port same-cycle read sees the old word
        step(1'b1, 1'b0, 2'b11, 6'd2, 16'h000F, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
        step(1'b1, 1'b0, 2'b11, 6'd2, 16'h00F0, 1'b0, 1'b1, 2'b00, 6'd2, 16'h0);
        step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0,    1'b0, 1'b1, 2'b00, 6'd2, 16'h0);

        // Depth boundary
        step(1'b1, 1'b0, 2'b11, 6'd50, 16'hDEAD, 1'b0, 1'b1, 2'b00, 6'd50, 16'h0);
        step(1'b1, 1'b0, 2'b11, 6'd47, 16'h4747, 1'b1, 1'b1, 2'b11, 6'd48, 16'hBAD0);
        step(1'b0, 1'b1, 2'b00, 6'd50, 16'h0,    1'b0, 1'b1, 2'b00, 6'd47, 16'h0);

        // Back-to-back reads
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 2'b00, AW'(k), 16'h0, 1'b0, 1'b1, 2'b00, AW'(47 - k), 16'h0);
        end

        for (int r = 0; r < 60; r++) begin
            rand_step();
        end
        idle_step();
        idle_step();

        // Reset with reads in flight; memory survives
        step(1'b0, 1'b1, 2'b00, 6'd3, 16'h0, 1'b0, 1'b1, 2'b00, 6'd7, 16'h0);
        reset_pulse(3);
        step(1'b0, 1'b1, 2'b00, 6'd3, 16'h0, 1'b0, 1'b1, 2'b00, 6'd7, 16'h0);
        step(1'b0, 1'b1, 2'b00, 6'd9, 16'h0, 1'b0, 1'b1, 2'b00, 6'd2, 16'h0);
        repeat (4) idle_step();

        @(negedge clk);
        check_outputs();
        for (int k = 0; k < NI*2; k++) begin
            check_val($sformatf("sb_drained %0d", k), 32'(sb[k].size()), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
